pio_bus_responder: RTL and testbench
====================================

Name: pio_bus_responder

Overview:
- Fabric-side responder for the PIO-bridged soft-processor bus: address[7:0], wdata[31:0], rdata[31:0], and control strobes, driven by processor software.
- Decodes the bus with a four-phase req/ack handshake.
- Holds the message/key register bank feeding the SHA-1/PBKDF2 core, issues start pulses, and returns status and digest words.
- Sits between the processor-system conduits and the hash core.

Parameters:
- ID_VALUE, 32'h57504132, constant returned at address 0x00 ("WPA2").
- MSG_WORDS, 16, number of 32-bit message/key words (512 bits).
- DIGEST_WORDS, 5, number of 32-bit digest words (160 bits).

Ports:
- clk_clk  in  1  single system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- bus_addr  in  8  word address from processor.
- bus_wdata  in  32  write data from processor.
- bus_rdata  out  32  read data to processor.
- bus_wr_req  in  1  write request, level, control bit 0.
- bus_rd_req  in  1  read request, level, control bit 1.
- bus_ack  out  1  handshake acknowledge, control bit 2.
- bus_err  out  1  error flag for current transfer, control bit 3.
- core_msg  out  32*MSG_WORDS  message bank; word 0 occupies bits [31:0].
- core_start  out  1  one-cycle start pulse.
- core_busy  in  1  core is running.
- core_done  in  1  one-cycle completion pulse.
- core_digest  in  32*DIGEST_WORDS  digest; word 0 occupies bits [31:0].
- irq  out  1  interrupt; only present with PIO_RSP_IRQ_EN.

Behaviour:
- Reset, asynchronous on reset_reset_n low:
  - bus_rdata=0, bus_ack=0, bus_err=0, core_start=0, irq=0.
  - All msg words 0, done_sticky=0, state=IDLE.
  - Reset mid-handshake aborts the transfer. After reset, a request still held high is treated as a new request.
- States: IDLE, WR_ACK, RD_ACK.
- IDLE:
  - wr_req=1, rd_req=0: perform the write at this edge (addr/wdata sampled here), next state WR_ACK, bus_ack=1 the following cycle (1-cycle latency).
  - rd_req=1, wr_req=0: latch decoded data into bus_rdata at this edge, next state RD_ACK, bus_ack=1 the following cycle.
  - Both high: no access, bus_err=1, next state WR_ACK.
- WR_ACK / RD_ACK:
  - Hold bus_ack=1 and bus_rdata stable while the owning request stays high. A request deasserting counts as low.
  - When the owning request is low: bus_ack=0, bus_err=0, go to IDLE. A new request is accepted no earlier than the cycle after ack drops.
- Address map, word addresses:
  - 0x00 RO: ID_VALUE.
  - 0x01 WO: bit0=1 produces a core_start pulse one cycle after the write edge. If core_busy=1 at the write, no pulse and bus_err=1. Reads return 0.
  - 0x02 RW: read {30'b0, done_sticky, core_busy}. Writing bit1=1 clears done_sticky.
  - 0x10..0x10+MSG_WORDS-1 RW: message words.
  - 0x20..0x20+DIGEST_WORDS-1 RO: digest words, sampled at read acceptance.
- Unmapped address, or a write to an RO address: no state change, read data 0, bus_err=1 held with ack.
- done_sticky: set on core_done.
  - If core_done and a clear write occur on the same edge, set wins (stays 1).
- Message writes while core_busy=1 are permitted. Keeping the bank stable during a run is software's responsibility.

Optional Feature:
- Macro: PIO_RSP_IRQ_EN.
- Defined:
  - irq port exists; irq = done_sticky & irq_enable.
  - irq_enable is bit0 of new RW register 0x03, reset 0.
  - irq is registered: it rises one cycle after done_sticky sets.
- Undefined:
  - No irq port and no register 0x03. Address 0x03 is unmapped (err=1, read 0).

Test Plan:
- Reset, then read 0x00: rd_req high → bus_ack=1 one cycle later with bus_rdata=32'h57504132 and bus_err=0. Drop rd_req → ack=0 next cycle.
- Write 32'hDEADBEEF to 0x13, then read 0x13: readback=32'hDEADBEEF, and core_msg[127:96]=32'hDEADBEEF.
- Write 1 to 0x01 with core_busy=0 → exactly one core_start cycle. Repeat with core_busy=1 → no pulse, bus_err=1.
- Pulse core_done, then read 0x02 → 32'h2. Write 32'h2 to 0x02, then read → 32'h0. Clear write and core_done on the same edge → read 32'h2.
- Read 0x7F, write 0x20, and assert wr_req and rd_req together → each gives ack with bus_err=1, rdata=0, and no register change.
- Drop reset_reset_n while in RD_ACK with rd_req held → ack=0 immediately. After release, the request is re-accepted and ack rises again.
- With PIO_RSP_IRQ_EN: write 1 to 0x03, pulse core_done → irq=1. Clear done_sticky → irq=0.

Source files
------------

// File: rtl/pio_bus_responder.sv
// ---------------------------------------------------------------------------
// pio_bus_responder
//
// Fabric-side responder for the PIO-bridged soft-processor bus. Software
// drives address/wdata and level-sensitive request strobes. This block
// answers with a four-phase req/ack handshake. It holds the message/key
// bank for the SHA-1/PBKDF2 core, issues start pulses, and returns status
// and digest words.
//
// Ports:
//   clk_clk        single system clock
//   reset_reset_n  asynchronous active-low reset
//   bus_addr       word address from the processor
//   bus_wdata      write data from the processor
//   bus_rdata      read data to the processor (latched at acceptance)
//   bus_wr_req     write request level
//   bus_rd_req     read request level
//   bus_ack        handshake acknowledge
//   bus_err        error flag for the current transfer
//   core_msg       message bank, word 0 in bits [31:0]
//   core_start     one-cycle start pulse to the hash core
//   core_busy      hash core running
//   core_done      one-cycle completion pulse from the hash core
//   core_digest    digest words, word 0 in bits [31:0]
//   irq            interrupt (only with PIO_RSP_IRQ_EN)
//
// Optional feature macro: PIO_RSP_IRQ_EN adds register 0x03 (irq enable)
// and the registered irq output.
// ---------------------------------------------------------------------------
module pio_bus_responder #(
    parameter logic [31:0] ID_VALUE     = 32'h57504132,
    parameter int          MSG_WORDS    = 16,
    parameter int          DIGEST_WORDS = 5
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset_n,
    input  logic [7:0]                bus_addr,
    input  logic [31:0]               bus_wdata,
    output logic [31:0]               bus_rdata,
    input  logic                      bus_wr_req,
    input  logic                      bus_rd_req,
    output logic                      bus_ack,
    output logic                      bus_err,
    output logic [32*MSG_WORDS-1:0]   core_msg,
    output logic                      core_start,
    input  logic                      core_busy,
    input  logic                      core_done,
    input  logic [32*DIGEST_WORDS-1:0] core_digest
`ifdef PIO_RSP_IRQ_EN
    ,
    output logic                      irq
`endif
);

    localparam logic [7:0] ADDR_ID     = 8'h00;
    localparam logic [7:0] ADDR_CTRL   = 8'h01;
    localparam logic [7:0] ADDR_STATUS = 8'h02;
`ifdef PIO_RSP_IRQ_EN
    localparam logic [7:0] ADDR_IRQ_EN = 8'h03;
`endif
    localparam logic [7:0] MSG_BASE    = 8'h10;
    localparam logic [7:0] MSG_CNT     = 8'(MSG_WORDS);
    localparam logic [7:0] DIG_BASE    = 8'h20;
    localparam logic [7:0] DIG_CNT     = 8'(DIGEST_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WR_ACK,
        RD_ACK
    } state_t;

    state_t                   state_q, state_d;
    logic                     ack_q, ack_d;
    logic                     err_q, err_d;
    logic [31:0]              rdata_q, rdata_d;
    logic                     start_q, start_d;
    logic [32*MSG_WORDS-1:0]  msg_q, msg_d;
    logic                     done_sticky_q, done_sticky_d;
    logic                     done_clr;
`ifdef PIO_RSP_IRQ_EN
    logic                     irq_en_q, irq_en_d;
    logic                     irq_q, irq_d;
`endif

    logic [7:0]  msg_off;
    logic [7:0]  dig_off;
    logic        msg_hit;
    logic        dig_hit;
    logic [31:0] rd_data;
    logic        rd_err;

    // Window offsets are computed by subtraction. A lower bound check keeps
    // addresses below the base from wrapping into the window.
    assign msg_off = bus_addr - MSG_BASE;
    assign dig_off = bus_addr - DIG_BASE;
    assign msg_hit = (bus_addr >= MSG_BASE) && (msg_off < MSG_CNT);
    assign dig_hit = (bus_addr >= DIG_BASE) && (dig_off < DIG_CNT);

    // Read decode. The control register is write-only but mapped, so a read
    // returns zero without an error.
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        if (bus_addr == ADDR_ID) begin
            rd_data = ID_VALUE;
        end else if (bus_addr == ADDR_CTRL) begin
            rd_data = '0;
        end else if (bus_addr == ADDR_STATUS) begin
            rd_data = {30'b0, done_sticky_q, core_busy};
`ifdef PIO_RSP_IRQ_EN
        end else if (bus_addr == ADDR_IRQ_EN) begin
            rd_data = {31'b0, irq_en_q};
`endif
        end else if (msg_hit) begin
            for (int i = 0; i < MSG_WORDS; i++) begin
                if (msg_off == 8'(i)) rd_data = msg_q[32*i +: 32];
            end
        end else if (dig_hit) begin
            for (int i = 0; i < DIGEST_WORDS; i++) begin
                if (dig_off == 8'(i)) rd_data = core_digest[32*i +: 32];
            end
        end else begin
            rd_err = 1'b1;
        end
    end

    // Handshake FSM and register side effects. Accesses take effect only on
    // the IDLE acceptance edge. The ack states just wait for the owning
    // request to drop, so a held request never repeats an access.
    always_comb begin
        state_d  = state_q;
        ack_d    = ack_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        start_d  = 1'b0;
        msg_d    = msg_q;
        done_clr = 1'b0;
`ifdef PIO_RSP_IRQ_EN
        irq_en_d = irq_en_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus_wr_req && bus_rd_req) begin
                    // Ambiguous request: no access. Wait on wr_req to drop.
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = WR_ACK;
                end else if (bus_wr_req) begin
                    ack_d   = 1'b1;
                    err_d   = 1'b0;
                    rdata_d = '0;
                    state_d = WR_ACK;
                    if (bus_addr == ADDR_CTRL) begin
                        if (bus_wdata[0]) begin
                            if (core_busy) err_d = 1'b1;
                            else           start_d = 1'b1;
                        end
                    end else if (bus_addr == ADDR_STATUS) begin
                        done_clr = bus_wdata[1];
`ifdef PIO_RSP_IRQ_EN
                    end else if (bus_addr == ADDR_IRQ_EN) begin
                        irq_en_d = bus_wdata[0];
`endif
                    end else if (msg_hit) begin
                        for (int i = 0; i < MSG_WORDS; i++) begin
                            if (msg_off == 8'(i)) msg_d[32*i +: 32] = bus_wdata;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus_rd_req) begin
                    ack_d   = 1'b1;
                    err_d   = rd_err;
                    rdata_d = rd_data;
                    state_d = RD_ACK;
                end
            end
            WR_ACK: begin
                if (!bus_wr_req) begin
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            RD_ACK: begin
                if (!bus_rd_req) begin
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        // A completion on the same edge as a clear wins, so no done is lost.
        done_sticky_d = core_done | (done_sticky_q & ~done_clr);
`ifdef PIO_RSP_IRQ_EN
        irq_d = done_sticky_q & irq_en_q;
`endif
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q       <= IDLE;
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
            start_q       <= 1'b0;
            msg_q         <= '0;
            done_sticky_q <= 1'b0;
`ifdef PIO_RSP_IRQ_EN
            irq_en_q      <= 1'b0;
            irq_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ack_q         <= ack_d;
            err_q         <= err_d;
            rdata_q       <= rdata_d;
            start_q       <= start_d;
            msg_q         <= msg_d;
            done_sticky_q <= done_sticky_d;
`ifdef PIO_RSP_IRQ_EN
            irq_en_q      <= irq_en_d;
            irq_q         <= irq_d;
`endif
        end
    end

    assign bus_ack    = ack_q;
    assign bus_err    = err_q;
    assign bus_rdata  = rdata_q;
    assign core_start = start_q;
    assign core_msg   = msg_q;
`ifdef PIO_RSP_IRQ_EN
    assign irq        = irq_q;
`endif

endmodule

// File: tb/tb_pio_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_pio_bus_responder
//
// Self-checking bench for pio_bus_responder. A register-level model, made of
// arrays plus a done flag, predicts every bus response. Directed steps cover
// the handshake, start, done and error cases and a reset mid-transfer. A
// randomized pass then mixes reads and writes across the address map.
// ---------------------------------------------------------------------------
module tb_pio_bus_responder;

    localparam logic [31:0] ID_WORD      = 32'h57504132;
    localparam int          MSG_WORDS    = 16;
    localparam int          DIGEST_WORDS = 5;

    logic                        clk_clk = 1'b0;
    logic                        reset_reset_n = 1'b0;
    logic [7:0]                  bus_addr = '0;
    logic [31:0]                 bus_wdata = '0;
    logic [31:0]                 bus_rdata;
    logic                        bus_wr_req = 1'b0;
    logic                        bus_rd_req = 1'b0;
    logic                        bus_ack;
    logic                        bus_err;
    logic [32*MSG_WORDS-1:0]     core_msg;
    logic                        core_start;
    logic                        core_busy = 1'b0;
    logic                        core_done = 1'b0;
    logic [32*DIGEST_WORDS-1:0]  core_digest = '0;
`ifdef PIO_RSP_IRQ_EN
    logic                        irq;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] model_msg [MSG_WORDS];
    logic        model_done = 1'b0;
    logic        model_irq_en = 1'b0;

    always #5 clk_clk = ~clk_clk;

    pio_bus_responder dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata),
        .bus_wr_req    (bus_wr_req),
        .bus_rd_req    (bus_rd_req),
        .bus_ack       (bus_ack),
        .bus_err       (bus_err),
        .core_msg      (core_msg),
        .core_start    (core_start),
        .core_busy     (core_busy),
        .core_done     (core_done),
        .core_digest   (core_digest)
`ifdef PIO_RSP_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    // One comparison: count it, and report a mismatch with tag and values.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Expected {err, data} of a read, taken from the register map.
    function automatic logic [32:0] modelRead(input logic [7:0] addr);
        int a;
        a = int'(addr);
        if (a == 0) return {1'b0, ID_WORD};
        if (a == 1) return 33'h0;
        if (a == 2) return {1'b0, 30'b0, model_done, core_busy};
`ifdef PIO_RSP_IRQ_EN
        if (a == 3) return {1'b0, 31'b0, model_irq_en};
`endif
        if (a >= 16 && a < 16 + MSG_WORDS) return {1'b0, model_msg[a - 16]};
        if (a >= 32 && a < 32 + DIGEST_WORDS) return {1'b0, core_digest[32*(a - 32) +: 32]};
        return {1'b1, 32'h0};
    endfunction

    // Applies a write to the model and predicts its err flag and start pulse.
    function automatic void modelWrite(input logic [7:0] addr, input logic [31:0] data,
                                       input logic busy, output logic err, output logic start);
        int a;
        a = int'(addr);
        err = 1'b0;
        start = 1'b0;
        if (a == 1) begin
            if (data[0]) begin
                if (busy) err = 1'b1;
                else      start = 1'b1;
            end
        end else if (a == 2) begin
            if (data[1]) model_done = 1'b0;
`ifdef PIO_RSP_IRQ_EN
        end else if (a == 3) begin
            model_irq_en = data[0];
`endif
        end else if (a >= 16 && a < 16 + MSG_WORDS) begin
            model_msg[a - 16] = data;
        end else begin
            err = 1'b1;
        end
    endfunction

    // Runs one full handshake: raise the request, check the acknowledge, hold
    // it for a few cycles, then drop it and check the acknowledge falls.
    task automatic applyStimulus(input string tag, input logic wr, input logic rd,
                                 input logic [7:0] addr, input logic [31:0] data,
                                 input logic done_pulse, input int hold);
        logic        exp_err;
        logic        exp_start;
        logic [31:0] exp_rdata;
        logic [32:0] r;
        exp_start = 1'b0;
        if (wr && rd) begin
            exp_err   = 1'b1;
            exp_rdata = '0;
        end else if (wr) begin
            modelWrite(addr, data, core_busy, exp_err, exp_start);
            exp_rdata = '0;
        end else begin
            r         = modelRead(addr);
            exp_err   = r[32];
            exp_rdata = r[31:0];
        end
        if (done_pulse) model_done = 1'b1;

        bus_addr   = addr;
        bus_wdata  = data;
        bus_wr_req = wr;
        bus_rd_req = rd;
        core_done  = done_pulse;
        @(posedge clk_clk); #1;
        core_done = 1'b0;
        checkOutput({tag, " ack"},   32'(bus_ack),    32'h1);
        checkOutput({tag, " err"},   32'(bus_err),    32'(exp_err));
        checkOutput({tag, " rdata"}, bus_rdata,       exp_rdata);
        checkOutput({tag, " start"}, 32'(core_start), 32'(exp_start));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_clk); #1;
            checkOutput({tag, " hold ack"},   32'(bus_ack),    32'h1);
            checkOutput({tag, " hold rdata"}, bus_rdata,       exp_rdata);
            checkOutput({tag, " hold start"}, 32'(core_start), 32'h0);
        end
        bus_wr_req = 1'b0;
        bus_rd_req = 1'b0;
        @(posedge clk_clk); #1;
        checkOutput({tag, " drop ack"},   32'(bus_ack),    32'h0);
        checkOutput({tag, " drop err"},   32'(bus_err),    32'h0);
        checkOutput({tag, " drop start"}, 32'(core_start), 32'h0);
    endtask

    initial begin
        logic [7:0]  addr;
        logic [31:0] data;
        int          kind;

        for (int i = 0; i < MSG_WORDS; i++) model_msg[i] = '0;
        for (int i = 0; i < DIGEST_WORDS; i++) core_digest[32*i +: 32] = $urandom;

        // Reset values while reset is held.
        #12;
        checkOutput("reset ack",   32'(bus_ack),    32'h0);
        checkOutput("reset err",   32'(bus_err),    32'h0);
        checkOutput("reset rdata", bus_rdata,       32'h0);
        checkOutput("reset start", 32'(core_start), 32'h0);
        checkOutput("reset msg3",  core_msg[127:96], 32'h0);
`ifdef PIO_RSP_IRQ_EN
        checkOutput("reset irq",   32'(irq),        32'h0);
`endif
        reset_reset_n = 1'b1;

        // ID read and a message write/readback.
        applyStimulus("read id", 1'b0, 1'b1, 8'h00, 32'h0, 1'b0, 1);
        applyStimulus("write msg3", 1'b1, 1'b0, 8'h13, 32'hDEADBEEF, 1'b0, 0);
        applyStimulus("read msg3", 1'b0, 1'b1, 8'h13, 32'h0, 1'b0, 2);
        checkOutput("core_msg word3", core_msg[127:96], 32'hDEADBEEF);

        // Start pulses: accepted when idle, refused while busy.
        core_busy = 1'b0;
        applyStimulus("start idle", 1'b1, 1'b0, 8'h01, 32'h1, 1'b0, 1);
        core_busy = 1'b1;
        applyStimulus("start busy", 1'b1, 1'b0, 8'h01, 32'h1, 1'b0, 0);
        applyStimulus("status busy", 1'b0, 1'b1, 8'h02, 32'h0, 1'b0, 0);
        core_busy = 1'b0;

        // Done sticky: set, clear, and a clear racing a new completion.
        core_done = 1'b1;
        @(posedge clk_clk); #1;
        core_done  = 1'b0;
        model_done = 1'b1;
        applyStimulus("status done", 1'b0, 1'b1, 8'h02, 32'h0, 1'b0, 0);
        applyStimulus("clear done", 1'b1, 1'b0, 8'h02, 32'h2, 1'b0, 0);
        applyStimulus("status clr", 1'b0, 1'b1, 8'h02, 32'h0, 1'b0, 0);
        applyStimulus("clear+done", 1'b1, 1'b0, 8'h02, 32'h2, 1'b1, 0);
        applyStimulus("status race", 1'b0, 1'b1, 8'h02, 32'h0, 1'b0, 0);

        // Error cases leave the registers untouched.
        applyStimulus("read unmapped", 1'b0, 1'b1, 8'h7F, 32'h0, 1'b0, 1);
        applyStimulus("write digest", 1'b1, 1'b0, 8'h20, 32'h12345678, 1'b0, 0);
        applyStimulus("both reqs", 1'b1, 1'b1, 8'h13, 32'h0, 1'b0, 1);
        applyStimulus("read id ro", 1'b1, 1'b0, 8'h00, 32'h1, 1'b0, 0);
        applyStimulus("msg3 intact", 1'b0, 1'b1, 8'h13, 32'h0, 1'b0, 0);
        applyStimulus("read digest0", 1'b0, 1'b1, 8'h20, 32'h0, 1'b0, 0);
        applyStimulus("read 0x03", 1'b0, 1'b1, 8'h03, 32'h0, 1'b0, 0);

        // Reset while a read is being acknowledged.
        bus_addr   = 8'h00;
        bus_rd_req = 1'b1;
        @(posedge clk_clk); #1;
        checkOutput("pre-reset ack", 32'(bus_ack), 32'h1);
        reset_reset_n = 1'b0;
        #1;
        checkOutput("mid-reset ack",   32'(bus_ack), 32'h0);
        checkOutput("mid-reset rdata", bus_rdata,    32'h0);
        checkOutput("mid-reset msg3",  core_msg[127:96], 32'h0);
        for (int i = 0; i < MSG_WORDS; i++) model_msg[i] = '0;
        model_done   = 1'b0;
        model_irq_en = 1'b0;
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(posedge clk_clk); #1;
        checkOutput("re-accept ack",   32'(bus_ack), 32'h1);
        checkOutput("re-accept rdata", bus_rdata,    ID_WORD);
        bus_rd_req = 1'b0;
        @(posedge clk_clk); #1;
        checkOutput("re-accept drop", 32'(bus_ack), 32'h0);

        // Randomized traffic across the map.
        for (int n = 0; n < 60; n++) begin
            core_busy = 1'($urandom_range(0, 1));
            for (int i = 0; i < DIGEST_WORDS; i++) core_digest[32*i +: 32] = $urandom;
            kind = int'($urandom_range(0, 3));
            data = $urandom;
            case (kind)
                0: begin
                    addr = 8'h10 + 8'($urandom_range(0, MSG_WORDS - 1));
                    applyStimulus("rand msg wr", 1'b1, 1'b0, addr, data, 1'b0,
                                  int'($urandom_range(0, 2)));
                end
                1: begin
                    addr = 8'h10 + 8'($urandom_range(0, MSG_WORDS - 1));
                    applyStimulus("rand msg rd", 1'b0, 1'b1, addr, data, 1'b0,
                                  int'($urandom_range(0, 2)));
                end
                2: begin
                    if ($urandom_range(0, 1) == 0) addr = 8'($urandom_range(0, 3));
                    else addr = 8'h20 + 8'($urandom_range(0, DIGEST_WORDS - 1));
                    applyStimulus("rand map rd", 1'b0, 1'b1, addr, data, 1'b0,
                                  int'($urandom_range(0, 2)));
                end
                default: begin
                    addr = 8'($urandom_range(0, 255));
                    case ($urandom_range(0, 2))
                        0:       applyStimulus("rand any wr", 1'b1, 1'b0, addr, data, 1'b0, 0);
                        1:       applyStimulus("rand any rd", 1'b0, 1'b1, addr, data, 1'b0, 0);
                        default: applyStimulus("rand both", 1'b1, 1'b1, addr, data, 1'b0, 0);
                    endcase
                end
            endcase
        end
        core_busy = 1'b0;
        for (int i = 0; i < MSG_WORDS; i++) begin
            checkOutput("final core_msg", core_msg[32*i +: 32], model_msg[i]);
        end

`ifdef PIO_RSP_IRQ_EN
        // Interrupt follows done_sticky one cycle later when enabled.
        applyStimulus("irq enable", 1'b1, 1'b0, 8'h03, 32'h1, 1'b0, 0);
        applyStimulus("clear pre-irq", 1'b1, 1'b0, 8'h02, 32'h2, 1'b0, 0);
        checkOutput("irq idle", 32'(irq), 32'h0);
        core_done = 1'b1;
        @(posedge clk_clk); #1;
        core_done  = 1'b0;
        model_done = 1'b1;
        checkOutput("irq lag", 32'(irq), 32'h0);
        @(posedge clk_clk); #1;
        checkOutput("irq set", 32'(irq), 32'h1);
        applyStimulus("irq clear", 1'b1, 1'b0, 8'h02, 32'h2, 1'b0, 0);
        checkOutput("irq cleared", 32'(irq), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
